// File: rtl/lock_controller.sv
// Keypad lock controller: code entry, unlock, reprogramming,
// error/success blink handshake and timed lockout after repeated failures.
module lock_controller #(
  parameter int                      CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                      MAX_FAIL       = 3,
  parameter logic [31:0]             LOCKOUT_CYCLES = 32'd120000000
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       prog_req,
  input  logic       lock_req,
  input  logic       done_blinking,
  output logic       start_blinking,
  output logic       blinkType,
  output logic       unlocked,
  output logic       lockout,
  output logic [2:0] entry_count
);

  localparam int W = 4 * CODE_LEN;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_PROG,
    S_BLINK_REQ,
    S_BLINK_WAIT,
    S_LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [W-1:0]  code_q, code_d;
  logic [3:0]    fail_q, fail_d;
  logic          btype_q, btype_d;
  logic          ack_q, ack_d;
  logic [31:0]   lo_q, lo_d;

  logic          full;
  logic          digit_ok;
  logic [W-1:0]  shifted;

  assign full     = (cnt_q == 3'(CODE_LEN));
  assign digit_ok = digit_valid && (digit <= 4'd9) && !full;
  assign shifted  = W'({buf_q, digit});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    code_d  = code_q;
    fail_d  = fail_q;
    btype_d = btype_q;
    ack_d   = ack_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_LOCKED: begin
        if (full) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else if (digit_ok) begin
          buf_d = shifted;
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_CHECK: begin
        if (buf_q == code_q) begin
          state_d = S_UNLOCKED;
          fail_d  = '0;
        end else begin
          if (fail_q < 4'(MAX_FAIL)) fail_d = fail_q + 4'd1;
          btype_d = 1'b0;
          state_d = S_BLINK_REQ;
        end
      end
      S_UNLOCKED: begin
        if (prog_req)      state_d = S_PROG;
        else if (lock_req) state_d = S_LOCKED;
      end
      S_PROG: begin
        if (lock_req) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else if (full) begin
          code_d  = buf_q;
          cnt_d   = '0;
          btype_d = 1'b1;
          state_d = S_BLINK_REQ;
        end else if (digit_ok) begin
          buf_d = shifted;
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_BLINK_REQ: begin
        ack_d   = 1'b0;
        state_d = S_BLINK_WAIT;
      end
      S_BLINK_WAIT: begin
        // a done level left over from the previous run must drop first
        if (!done_blinking) begin
          ack_d = 1'b1;
        end else if (ack_q) begin
          if (!btype_q && fail_q == 4'(MAX_FAIL)) state_d = S_LOCKOUT;
          else                                    state_d = S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        if (lo_q + 32'd1 >= LOCKOUT_CYCLES) begin
          lo_d    = '0;
          fail_d  = '0;
          state_d = S_LOCKED;
        end else begin
          lo_d = lo_q + 32'd1;
        end
      end
      default: state_d = S_LOCKED;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      cnt_q   <= '0;
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE;
      fail_q  <= '0;
      btype_q <= 1'b0;
      ack_q   <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      fail_q  <= fail_d;
      btype_q <= btype_d;
      ack_q   <= ack_d;
      lo_q    <= lo_d;
    end
  end

  assign start_blinking = (state_q == S_BLINK_WAIT);
  assign blinkType      = btype_q;
  assign unlocked       = (state_q == S_UNLOCKED) || (state_q == S_PROG);
  assign lockout        = (state_q == S_LOCKOUT);
  assign entry_count    = cnt_q;

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning the number of digits per code (range 1..7).
REQ-002 SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning the code loaded at reset; digit 0 sits in the MSB nibble, width 4*CODE_LEN.
REQ-003 SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive wrong entries that triggers lockout (range 1..15).
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 32'd120000000, meaning the lockout duration in hwclk cycles.
REQ-005 SHALL have port hwclk, input, 1 bit: the single system clock; all logic is on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port digit_valid, input, 1 bit: one-cycle pulse meaning a keypad digit is present.
REQ-008 SHALL have port digit, input, 4 bits: digit value, qualified by digit_valid.
REQ-009 SHALL have port prog_req, input, 1 bit: one-cycle pulse requesting code programming.
REQ-010 SHALL have port lock_req, input, 1 bit: one-cycle pulse requesting relock.
REQ-011 SHALL have port done_blinking, input, 1 bit: completion level from the downstream blinker.
REQ-012 SHALL have port start_blinking, output, 1 bit: level request to the blinker; the blinker acts on its rising edge.
REQ-013 SHALL have port blinkType, output, 1 bit: 0 = error pattern, 1 = programming-success pattern.
REQ-014 SHALL have port unlocked, output, 1 bit: high while in the UNLOCKED state.
REQ-015 SHALL have port lockout, output, 1 bit: high while in the LOCKOUT state.
REQ-016 SHALL have port entry_count, output, 3 bits: number of digits accepted in the current entry.

Function
REQ-017 SHALL implement the states LOCKED, CHECK, UNLOCKED, PROG, BLINK_REQ, BLINK_WAIT and LOCKOUT, one-hot or encoded.
REQ-018 SHALL accept a digit only when digit_valid=1, digit<=9, and the state is LOCKED or PROG; digits 10..15 are ignored and entry_count is unchanged.
REQ-019 SHALL handle an accepted digit by shifting it into the entry buffer and incrementing entry_count, both registered the same cycle.
REQ-020 SHALL, in LOCKED, go to CHECK the cycle after entry_count reaches CODE_LEN.
REQ-021 SHALL resolve CHECK in 1 cycle with entry_count cleared.
REQ-022 SHALL, on a CHECK match, go to UNLOCKED and clear fail_cnt.
REQ-023 SHALL, on a CHECK mismatch, increment fail_cnt (saturating), set blinkType=0 and go to BLINK_REQ.
REQ-024 SHALL, in UNLOCKED: prog_req goes to PROG; lock_req goes to LOCKED; if both occur in the same cycle, prog_req wins; digits are ignored.
REQ-025 SHALL, in PROG, when entry_count reaches CODE_LEN, write the entry buffer into the code register, clear entry_count, set blinkType=1 and go to BLINK_REQ.
REQ-026 SHALL hold unlocked=1 in PROG.
REQ-027 SHALL keep lock_req in PROG aborting programming: go to LOCKED, leave the code unchanged and clear entry_count.
REQ-028 SHALL, on entering BLINK_REQ, hold blinkType stable and raise start_blinking the next cycle, so blinkType is valid at least 1 cycle before the rising edge and throughout the request.
REQ-029 SHALL, in BLINK_WAIT, keep start_blinking high and first require done_blinking=0 (blinker acknowledged), then done_blinking=1; a stale done_blinking=1 from a prior run SHALL NOT end the wait.
REQ-030 SHALL, on completing BLINK_WAIT, drop start_blinking and go to the next state as follows:
- after an error blink with fail_cnt==MAX_FAIL, go to LOCKOUT;
- after any other error blink, go to LOCKED;
- after a success blink, go to LOCKED.
REQ-031 SHALL, in LOCKOUT, assert lockout, ignore all inputs and count LOCKOUT_CYCLES using a 32-bit counter; at terminal count it clears fail_cnt and goes to LOCKED.
REQ-032 SHALL ignore digit_valid, prog_req and lock_req in CHECK, BLINK_REQ, BLINK_WAIT and LOCKOUT.
REQ-033 SHALL hold start_blinking at most one request at a time and never re-raise it without first being low for at least 1 cycle.

Reset
REQ-034 SHALL, on rst_n=0 at a posedge, set the state to LOCKED and reset all outputs as follows:
- start_blinking=0, blinkType=0, unlocked=0, lockout=0, entry_count=0;
- fail_cnt=0 and the lockout counter=0;
- the code register reloads DEFAULT_CODE.
REQ-035 SHALL let reset override everything, including reset mid-blink (start_blinking drops the next cycle) and mid-lockout.

Verification
REQ-036 SHALL cover: after reset, enter 1,2,3,4 -> CHECK, then unlocked=1 two cycles after the 4th digit, with no start_blinking.
REQ-037 SHALL cover: enter 1,2,3,5 -> start_blinking rises with blinkType=0; the blinker model sends done 0 then 1; start drops; state returns to LOCKED with unlocked=0.
REQ-038 SHALL cover: three wrong entries -> the third blink completes, lockout=1 for exactly LOCKOUT_CYCLES (set to 100 in the bench), and digits during lockout have no effect.
REQ-039 SHALL cover: unlock, prog_req, enter 9,8,7,6 -> blinkType=1 blink, then LOCKED; 1,2,3,4 then fails and 9,8,7,6 then unlocks.
REQ-040 SHALL cover: digit 4'hC pulsed during entry -> entry_count is unchanged.
REQ-041 SHALL cover: done_blinking held 1 when start_blinking rises -> start_blinking stays high until done goes 0 then 1.
REQ-042 SHALL cover: rst_n low during BLINK_WAIT -> all outputs are 0 the next cycle and the code returns to 16'h1234.
